// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA line-fetch block.
// The defaults are for an 800x600 visible raster with an RGB444 pixel.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  localparam int DEF_HACTIVE    = 800;
  localparam int DEF_VACTIVE    = 600;
  localparam int DEF_HVID_START = 192;
  localparam int DEF_VVID_START = 21;

  localparam int              DEF_PIXW           = 12;
  localparam logic [11:0]     DEF_UNDERRUN_COLOR = 12'hF00;

endpackage

// File: rtl/vga_line_buffer.sv
// Ping-pong line store: two banks of DEPTH pixels, one write port, one read port.
// Read data is registered (1-cycle latency); there is no flow control.
module vga_line_buffer #(
  parameter int DEPTH = vga_pkg::DEF_HACTIVE,
  parameter int PIXW  = vga_pkg::DEF_PIXW,
  parameter int BAW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            wr_bank,
  input  logic [BAW-1:0]  wr_addr,
  input  logic [PIXW-1:0] wr_data,
  input  logic            rd_bank,
  input  logic [BAW-1:0]  rd_addr,
  output logic [PIXW-1:0] rd_data
);

  logic [PIXW-1:0] mem0 [DEPTH];
  logic [PIXW-1:0] mem1 [DEPTH];

  // No reset on the storage so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wr_bank) mem1[wr_addr] <= wr_data;
      else         mem0[wr_addr] <= wr_data;
    end
    rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Prefetches the next visible row into a ping-pong buffer and emits pixels 2 cycles after the timer.
// Requests stall on rd_ready; a row not ready at display time shows UNDERRUN_COLOR and sets underrun.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int HACTIVE    = DEF_HACTIVE,
  parameter int VACTIVE    = DEF_VACTIVE,
  parameter int HVID_START = DEF_HVID_START,
  parameter int VVID_START = DEF_VVID_START,
  parameter int XW         = 17,
  parameter int YW         = 17,
  parameter int PIXW       = DEF_PIXW,
  parameter int AW         = 20,
  parameter int FB_BASE    = 0,
  parameter logic [PIXW-1:0] UNDERRUN_COLOR = PIXW'(DEF_UNDERRUN_COLOR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hsync_i,
  input  logic            vsync_i,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  input  logic            validpixel,
  output logic            rd_req,
  output logic [AW-1:0]   rd_addr,
  input  logic            rd_ready,
  input  logic            rd_valid,
  input  logic [PIXW-1:0] rd_data,
  output logic [PIXW-1:0] pix,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            de_o,
  output logic            underrun,
  input  logic            underrun_clr
);

  localparam int CW  = $clog2(HACTIVE + 1);
  localparam int BAW = $clog2(HACTIVE);
  localparam logic [CW-1:0] LAST_COL = CW'(HACTIVE - 1);
  localparam logic [CW-1:0] FULL_COL = CW'(HACTIVE);
  localparam logic          VPAR     = 1'(VVID_START % 2);

  fetch_state_t    state, state_nxt;
  logic [YW-1:0]   row;
  logic            trig;
  logic [AW-1:0]   base;
  logic [CW-1:0]   req_col, rsp_col;
  logic            fetch_bank;
  logic [1:0]      line_ready;
  logic            wr_en;
  logic [BAW-1:0]  disp_col;
  logic            disp_bank;
  logic [PIXW-1:0] buf_q;
  logic            vld1, ok1, hs1, vs1;
  logic            underrun_set;

  // Row fetched during this line is the one displayed on the next line.
  assign row       = y - YW'(VVID_START - 1);
  assign trig      = (x == '0) && (row < YW'(VACTIVE));
  assign wr_en     = rd_valid && (state != IDLE);
  assign disp_col  = x[BAW-1:0] - BAW'(HVID_START);
  assign disp_bank = y[0] ^ VPAR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = REQ;
      REQ:     if (rd_ready && (req_col == LAST_COL)) state_nxt = WAIT;
      WAIT:    if (rsp_col == FULL_COL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_req  = (state == REQ);
    rd_addr = base + AW'(req_col);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= AW'(FB_BASE);
      req_col    <= '0;
      rsp_col    <= '0;
      fetch_bank <= 1'b0;
      line_ready <= 2'b00;
    end else begin
      if ((state == IDLE) && trig) begin
        fetch_bank             <= row[0];
        base                   <= (row == '0) ? AW'(FB_BASE) : base + AW'(HACTIVE);
        req_col                <= '0;
        rsp_col                <= '0;
        line_ready[row[0]]     <= 1'b0;
      end
      if ((state == REQ) && rd_ready) req_col <= req_col + 1'b1;
      if (wr_en) begin
        rsp_col <= rsp_col + 1'b1;
        if (rsp_col == LAST_COL) line_ready[fetch_bank] <= 1'b1;
      end
    end
  end

  vga_line_buffer #(
    .DEPTH (HACTIVE),
    .PIXW  (PIXW),
    .BAW   (BAW)
  ) u_buf (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (fetch_bank),
    .wr_addr (rsp_col[BAW-1:0]),
    .wr_data (rd_data),
    .rd_bank (disp_bank),
    .rd_addr (disp_col),
    .rd_data (buf_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1    <= 1'b0;
      ok1     <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      pix     <= '0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      de_o    <= 1'b0;
    end else begin
      vld1    <= validpixel;
      ok1     <= line_ready[disp_bank];
      hs1     <= hsync_i;
      vs1     <= vsync_i;
      pix     <= !vld1 ? '0 : (ok1 ? buf_q : UNDERRUN_COLOR);
      hsync_o <= hs1;
      vsync_o <= vs1;
      de_o    <= vld1;
    end
  end

  // A dropped trigger and a visible pixel from an unfilled bank both count as underrun.
  assign underrun_set = (trig && (state != IDLE)) || (validpixel && !line_ready[disp_bank]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Sits directly downstream of the video timer; consumes its hsync/vsync/x/y/validpixel stream.
- Prefetches the next visible row from a framebuffer over a read request/response interface into a ping-pong line buffer.
- Emits pixel data aligned with delayed sync and data-enable to the VGA output pins.
- Flags underrun when a row is not fully fetched by display time.

Parameters:
- HACTIVE, 800, visible pixels per line
- VACTIVE, 600, visible lines per frame
- HVID_START, 192, raw x of first visible pixel
- VVID_START, 21, raw y of first visible line
- XW, 17, width of x input
- YW, 17, width of y input
- PIXW, 12, pixel width (RGB444)
- AW, 20, framebuffer word address width
- FB_BASE, 0, word address of pixel (0,0)
- UNDERRUN_COLOR, 12'hF00, pixel value emitted on underrun

Ports:
- clk  in  1  pixel clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- hsync_i  in  1  timer hsync
- vsync_i  in  1  timer vsync
- x  in  XW  timer raw column
- y  in  YW  timer raw row
- validpixel  in  1  qualifies x,y presented in the same cycle as visible
- rd_req  out  1  read request valid
- rd_addr  out  AW  pixel word address
- rd_ready  in  1  request accepted when rd_req&rd_ready
- rd_valid  in  1  response valid; responses return in order, any latency
- rd_data  in  PIXW  response pixel
- pix  out  PIXW  output pixel
- hsync_o  out  1  hsync_i delayed 2 cycles
- vsync_o  out  1  vsync_i delayed 2 cycles
- de_o  out  1  validpixel delayed 2 cycles
- underrun  out  1  sticky error flag
- underrun_clr  in  1  clears underrun

Behaviour:
- Reset: pix=0, hsync_o=0, vsync_o=0, de_o=0, rd_req=0, rd_addr=FB_BASE, underrun=0, FSM=IDLE, line_ready[1:0]=0, all counters 0.
- Fetch trigger: cycle with x==0 and r=y-VVID_START+1 in [0,VACTIVE-1]. Row r is written to bank r[0].
- Row base address: register set to FB_BASE when r==0, else previous base+HACTIVE. No multiplier.
- FSM states:
  - IDLE: on trigger, clear line_ready[r[0]], reset req_col and rsp_col, go to REQ.
  - REQ: rd_req=1, rd_addr=base+req_col. req_col advances only on rd_req&rd_ready. rd_addr is held stable while not accepted. After column HACTIVE-1 is accepted, go to WAIT.
  - WAIT: rd_req=0. Go to IDLE when rsp_col reaches HACTIVE.
  - Responses are counted in REQ and WAIT alike. Each rd_valid writes rd_data to bank[r[0]][rsp_col] and increments rsp_col. On the final response, set line_ready[r[0]].
  - rd_valid in IDLE is ignored.
- Trigger while not IDLE: trigger dropped, underrun set, current fetch continues unchanged.
- Display pipeline:
  - Stage 0: col=x-HVID_START, bank=(y-VVID_START)[0], read line buffer.
  - Stage 1: RAM data (1-cycle read).
  - Stage 2: registered outputs.
  - Latency exactly 2 cycles for pix, hsync_o, vsync_o and de_o.
- Pixel selection:
  - validpixel=0: pix=0.
  - validpixel=1 and line_ready[bank]=1: pix=buffer data.
  - validpixel=1 and line_ready[bank]=0: pix=UNDERRUN_COLOR and underrun set.
- underrun: set has priority over underrun_clr in the same cycle.
- Same bank written while displayed: cannot occur in correct operation, since the fetch of row r+2 starts only at the line after row r is shown. No interlock needed.
- Reset asserted mid-fetch: all state returns to reset values immediately. In-flight memory responses after reset are ignored, because the FSM is in IDLE.
- Subtraction widths: computed at XW/YW. Results are only meaningful when validpixel or the trigger range check is true.

Decomposition:
- Shared package vga_pkg holds:
  - FSM state enum: IDLE, REQ, WAIT.
  - Default timing constants: HACTIVE, VACTIVE, HVID_START, VVID_START.
  - PIXW and the default UNDERRUN_COLOR.
- One sub-module, vga_line_buffer: two banks of HACTIVE x PIXW, one write port (bank, addr, data, we) and one registered read port (bank, addr). Inferable as block RAM.

Test Plan:
- Reset: hold rst_n=0 with inputs toggling -> all outputs 0, rd_req=0, rd_addr=FB_BASE; release -> first rd_req only at the trigger with y=20, x=0.
- Zero-wait memory: rd_ready=1, rd_valid the cycle after acceptance, rd_data=addr[11:0] -> row 0 pixel at col 5 outputs pix=12'h005 exactly 2 cycles after validpixel with x=197; underrun stays 0 for a full frame.
- Backpressure: rd_ready toggles 1,0,0,1 -> rd_addr stable while rd_req&!rd_ready; exactly HACTIVE accepts per row; no address skipped or repeated.
- Underrun: memory never asserts rd_valid -> visible pixels equal 12'hF00 and underrun=1; underrun_clr pulse -> 0, then re-set on the next visible pixel.
- Frame wrap: run 2 frames -> first request of each frame is FB_BASE; row 599 first request is FB_BASE+599*800.
- Mid-fetch reset: assert rst_n=0 after 100 accepts, then release -> FSM in IDLE, line_ready=0, late rd_valid does not write the buffer or change rsp_col.
